// File: rtl/instr_encode_loader.sv
// Field-to-word MIPS encoder that streams encoded instructions into imem at
// consecutive addresses; used to preload test programs before the core runs.
module instr_encode_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm16,
    input  logic [25:0]       in_index,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              full_q, full_d;
    logic              stopPend_q, stopPend_d;
    logic              we_q, we_d;
    logic              err_q, err_d;

    logic [31:0]       encWord;
    logic              opValid;
    logic              accept;
    logic              atMax;

    always_comb begin
        encWord = '0;
        opValid = 1'b1;
        case (in_op)
            4'd0:    encWord = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
            4'd1:    encWord = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h21};
            4'd2:    encWord = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
            4'd3:    encWord = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
            4'd4:    encWord = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h27};
            4'd5:    encWord = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22};
            4'd6:    encWord = {6'h08, in_rs, in_rt, in_imm16};
            4'd7:    encWord = {6'h0C, in_rs, in_rt, in_imm16};
            4'd8:    encWord = {6'h04, in_rs, in_rt, in_imm16};
            4'd9:    encWord = {6'h23, in_rs, in_rt, in_imm16};
            4'd10:   encWord = {6'h2B, in_rs, in_rt, in_imm16};
            4'd11:   encWord = {6'h02, in_index};
            default: opValid = 1'b0;
        endcase
    end

    assign busy     = (state_q == LOAD);
    assign done     = (state_q == DONE);
    assign full     = full_q;
    assign in_ready = busy && !stopPend_q;
    assign accept   = in_valid && in_ready;
    assign atMax    = (ptr_q == {ADDR_W{1'b1}});

    // rst masks the registered strobes so a write already staged for this
    // cycle never reaches imem while reset is being applied.
    assign imem_we    = we_q && !rst;
    assign err        = err_q && !rst;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        full_d     = full_q;
        stopPend_d = stopPend_q;
        we_d       = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = LOAD;
                    ptr_d      = BASE;
                    full_d     = 1'b0;
                    stopPend_d = 1'b0;
                end
            end
            LOAD: begin
                // The final write drains one cycle before the session closes.
                if (stopPend_q) begin
                    state_d    = DONE;
                    stopPend_d = 1'b0;
                end else if (accept) begin
                    if (opValid) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = encWord;
                        if (atMax) begin
                            full_d     = 1'b1;
                            stopPend_d = 1'b1;
                        end else begin
                            ptr_d = ptr_q + ADDR_W'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    if (in_last) begin
                        stopPend_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= BASE;
            addr_q     <= '0;
            wdata_q    <= '0;
            full_q     <= 1'b0;
            stopPend_q <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            full_q     <= full_d;
            stopPend_q <= stopPend_d;
            we_q       <= we_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: a default-size instance for encoding
// and session control, and a 4-word instance for the fill-to-capacity case.
module tb_instr_encode_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, inValid, inLast;
    logic [3:0]  inOp;
    logic [4:0]  inRs, inRt, inRd;
    logic [15:0] inImm;
    logic [25:0] inIndex;
    logic        inReady, imemWe, busy, done, full, err;
    logic [7:0]  imemAddr;
    logic [31:0] imemWdata;

    logic        sStart, sValid;
    logic        sReady, sWe, sBusy, sDone, sFull, sErr;
    logic [1:0]  sAddr;
    logic [31:0] sWdata;

    int testCount = 0;
    int failCount = 0;

    logic [3:0]  tOp  [6] = '{4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd10};
    logic [31:0] tExp [6] = '{32'h00221824, 32'h00221825, 32'h00221827,
                              32'h20221234, 32'h30221234, 32'hAC221234};

    always #5 clk = ~clk;

    instr_encode_loader #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(inValid), .in_ready(inReady),
        .in_op(inOp), .in_rs(inRs), .in_rt(inRt), .in_rd(inRd), .in_imm16(inImm),
        .in_index(inIndex), .in_last(inLast), .imem_we(imemWe), .imem_addr(imemAddr),
        .imem_wdata(imemWdata), .busy(busy), .done(done), .full(full), .err(err)
    );

    instr_encode_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
        .clk(clk), .rst(rst), .start(sStart), .in_valid(sValid), .in_ready(sReady),
        .in_op(inOp), .in_rs(inRs), .in_rt(inRt), .in_rd(inRd), .in_imm16(inImm),
        .in_index(inIndex), .in_last(inLast), .imem_we(sWe), .imem_addr(sAddr),
        .imem_wdata(sWdata), .busy(sBusy), .done(sDone), .full(sFull), .err(sErr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [15:0] imm,
                                 input logic [25:0] idx, input logic last, input logic valid);
        inOp    = op;
        inRs    = rs;
        inRt    = rt;
        inRd    = rd;
        inImm   = imm;
        inIndex = idx;
        inLast  = last;
        inValid = valid;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sStart = 1'b0; sValid = 1'b0;
        applyStimulus(4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0, 1'b0);
        step();
        step();
        checkOutput("rst_we", {31'd0, imemWe}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_ready", {31'd0, inReady}, 32'd0);
        checkOutput("rst_addr", {24'd0, imemAddr}, 32'd0);
        rst = 1'b0;

        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("start_busy", {31'd0, busy}, 32'd1);
        checkOutput("start_ready", {31'd0, inReady}, 32'd1);

        applyStimulus(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 1'b1);
        step();
        checkOutput("add_we", {31'd0, imemWe}, 32'd1);
        checkOutput("add_addr", {24'd0, imemAddr}, 32'd0);
        checkOutput("add_wdata", imemWdata, 32'h00221820);
        inValid = 1'b0;
        step();
        checkOutput("idle_we", {31'd0, imemWe}, 32'd0);

        applyStimulus(4'd13, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0, 1'b0, 1'b1);
        step();
        checkOutput("badop_err", {31'd0, err}, 32'd1);
        checkOutput("badop_we", {31'd0, imemWe}, 32'd0);
        applyStimulus(4'd8, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0, 1'b0, 1'b1);
        step();
        checkOutput("beq_err", {31'd0, err}, 32'd0);
        checkOutput("beq_addr", {24'd0, imemAddr}, 32'd1);
        checkOutput("beq_wdata", imemWdata, 32'h1022FFFF);

        applyStimulus(4'd9, 5'd29, 5'd8, 5'd0, 16'h0004, 26'd0, 1'b0, 1'b1);
        step();
        checkOutput("lw_we", {31'd0, imemWe}, 32'd1);
        checkOutput("lw_addr", {24'd0, imemAddr}, 32'd2);
        checkOutput("lw_wdata", imemWdata, 32'h8FA80004);
        applyStimulus(4'd11, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10, 1'b1, 1'b1);
        step();
        checkOutput("j_addr", {24'd0, imemAddr}, 32'd3);
        checkOutput("j_wdata", imemWdata, 32'h08000010);
        checkOutput("j_ready", {31'd0, inReady}, 32'd0);
        applyStimulus(4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0, 1'b0);
        step();
        checkOutput("last_done", {31'd0, done}, 32'd1);
        checkOutput("last_busy", {31'd0, busy}, 32'd0);
        checkOutput("last_we", {31'd0, imemWe}, 32'd0);
        step();
        checkOutput("done_hold", {31'd0, done}, 32'd1);

        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("restart_done", {31'd0, done}, 32'd0);
        applyStimulus(4'd1, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0, 1'b1);
        step();
        checkOutput("addu_addr", {24'd0, imemAddr}, 32'd0);
        checkOutput("addu_wdata", imemWdata, 32'h00000021);
        start = 1'b1;
        applyStimulus(4'd5, 5'd3, 5'd4, 5'd5, 16'd0, 26'd0, 1'b0, 1'b1);
        step();
        start = 1'b0;
        checkOutput("busystart_addr", {24'd0, imemAddr}, 32'd1);
        checkOutput("sub_wdata", imemWdata, 32'h00642822);
        checkOutput("busystart_busy", {31'd0, busy}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(tOp[i], 5'd1, 5'd2, 5'd3, 16'h1234, 26'd0, 1'b0, 1'b1);
            step();
            checkOutput($sformatf("tbl%0d_we", i), {31'd0, imemWe}, 32'd1);
            checkOutput($sformatf("tbl%0d_addr", i), {24'd0, imemAddr}, 32'(i + 2));
            checkOutput($sformatf("tbl%0d_wdata", i), imemWdata, tExp[i]);
        end

        applyStimulus(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 1'b1);
        step();
        inValid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rstflight_we", {31'd0, imemWe}, 32'd0);
        step();
        checkOutput("rstflight_busy", {31'd0, busy}, 32'd0);
        checkOutput("rstflight_done", {31'd0, done}, 32'd0);
        checkOutput("rstflight_we2", {31'd0, imemWe}, 32'd0);
        checkOutput("rstflight_wdata", imemWdata, 32'd0);
        rst = 1'b0;

        start = 1'b1;
        step();
        start = 1'b0;
        applyStimulus(4'd14, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1, 1'b1);
        step();
        checkOutput("badlast_err", {31'd0, err}, 32'd1);
        checkOutput("badlast_we", {31'd0, imemWe}, 32'd0);
        applyStimulus(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 1'b0);
        step();
        checkOutput("badlast_done", {31'd0, done}, 32'd1);
        checkOutput("badlast_full", {31'd0, full}, 32'd0);

        sStart = 1'b1;
        step();
        sStart = 1'b0;
        sValid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checkOutput($sformatf("small%0d_we", k), {31'd0, sWe}, 32'd1);
            checkOutput($sformatf("small%0d_addr", k), {30'd0, sAddr}, 32'(k));
        end
        checkOutput("small_full", {31'd0, sFull}, 32'd1);
        checkOutput("small_ready", {31'd0, sReady}, 32'd0);
        step();
        checkOutput("small_5th_we", {31'd0, sWe}, 32'd0);
        checkOutput("small_done", {31'd0, sDone}, 32'd1);
        sValid = 1'b0;
        step();
        checkOutput("small_full_hold", {31'd0, sFull}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
